// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// alu_exec_stage : registered execute stage around an external ALU, with an
//                  operand register, 2-entry result queue and overflow stats.
// Revision       : 1.0
// ============================================================================
module alu_exec_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_W      = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_A,
  input  logic [DATA_WIDTH-1:0] in_B,
  input  logic [2:0]            in_ALUop,
  input  logic [TAG_W-1:0]      in_tag,
  output logic [DATA_WIDTH-1:0] alu_A,
  output logic [DATA_WIDTH-1:0] alu_B,
  output logic [2:0]            alu_ALUop,
  input  logic [DATA_WIDTH-1:0] alu_Result,
  input  logic                  alu_Zero,
  input  logic                  alu_Overflow,
  input  logic                  alu_CarryOut,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_zero,
  output logic                  out_overflow,
  output logic                  out_carry,
  output logic                  out_illegal,
  output logic [TAG_W-1:0]      out_tag,
  input  logic                  stat_clear,
  output logic                  ovf_sticky,
  output logic [CNT_W-1:0]      ovf_count
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic                  zero;
    logic                  overflow;
    logic                  carry;
    logic                  illegal;
    logic [TAG_W-1:0]      tag;
  } entry_t;

  // Operand register
  logic                  op_valid_q, op_valid_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [2:0]            op_q, op_d;
  logic [TAG_W-1:0]      tag_q, tag_d;

  // Result queue
  entry_t                mem_q [2];
  entry_t                mem_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;

  // Statistics
  logic                  ovf_sticky_q, ovf_sticky_d;
  logic [CNT_W-1:0]      ovf_count_q, ovf_count_d;

  logic                  in_fire, out_fire, adv;
  logic                  is_addsub, is_legal, ovf_inc;
  entry_t                cap, head;

  always_comb begin
    out_fire = (count_q != 2'd0) & out_ready;
    adv      = op_valid_q & ((count_q != 2'd2) | out_fire);
    in_fire  = in_valid & (~op_valid_q | adv);
  end

  // Flags from the ALU are only meaningful for ADD/SUB; elsewhere they may be X.
  always_comb begin
    is_addsub    = (op_q == OP_ADD) || (op_q == OP_SUB);
    is_legal     = is_addsub || (op_q == OP_AND) || (op_q == OP_OR) || (op_q == OP_SLT);
    cap.tag      = tag_q;
    cap.illegal  = ~is_legal;
    cap.result   = is_legal  ? alu_Result   : '0;
    cap.zero     = is_legal  ? alu_Zero     : 1'b1;
    cap.overflow = is_addsub ? alu_Overflow : 1'b0;
    cap.carry    = is_addsub ? alu_CarryOut : 1'b0;
  end

  always_comb begin
    op_valid_d = op_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    tag_d      = tag_q;
    if (in_fire) begin
      op_valid_d = 1'b1;
      a_d        = in_A;
      b_d        = in_B;
      op_d       = in_ALUop;
      tag_d      = in_tag;
    end else if (adv) begin
      op_valid_d = 1'b0;
    end
  end

  // When full, the write slot equals the slot being popped, so a concurrent
  // write and read at count==2 keeps order intact.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (adv) begin
      mem_d[wr_ptr_q] = cap;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (out_fire) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({adv, out_fire})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    ovf_inc      = adv & cap.overflow;
    ovf_sticky_d = ovf_sticky_q;
    ovf_count_d  = ovf_count_q;
    if (stat_clear) begin
      ovf_sticky_d = ovf_inc;
      ovf_count_d  = ovf_inc ? CNT_W'(1) : '0;
    end else if (ovf_inc) begin
      ovf_sticky_d = 1'b1;
      if (ovf_count_q != {CNT_W{1'b1}}) begin
        ovf_count_d = ovf_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_valid_q   <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      tag_q        <= '0;
      mem_q[0]     <= '0;
      mem_q[1]     <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      ovf_sticky_q <= 1'b0;
      ovf_count_q  <= '0;
    end else begin
      op_valid_q   <= op_valid_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      tag_q        <= tag_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_sticky_q <= ovf_sticky_d;
      ovf_count_q  <= ovf_count_d;
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign in_ready     = ~op_valid_q | adv;
  assign alu_A        = a_q;
  assign alu_B        = b_q;
  assign alu_ALUop    = op_q;
  assign out_valid    = (count_q != 2'd0);
  assign out_result   = head.result;
  assign out_zero     = head.zero;
  assign out_overflow = head.overflow;
  assign out_carry    = head.carry;
  assign out_illegal  = head.illegal;
  assign out_tag      = head.tag;
  assign ovf_sticky   = ovf_sticky_q;
  assign ovf_count    = ovf_count_q;

endmodule
`default_nettype wire

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Registered execute stage wrapped around the combinational ALU (3-bit ALUop: AND=000, OR=001, ADD=010, SUB=110, SLT=111).
- Accepts operand packets from issue over valid/ready and drives them into the ALU from an operand register.
- Captures Result/Zero/Overflow/CarryOut into a 2-entry output queue, sanitises the flags, and presents tagged results to writeback over valid/ready.
- Keeps a sticky overflow status and a saturating overflow counter.

Parameters:
- DATA_WIDTH, 32, operand/result width; must match the ALU.
- TAG_W, 4, width of the opaque tag carried alongside each packet.
- CNT_W, 16, width of the overflow event counter.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand packet valid.
- in_ready  out  1  stage can accept a packet.
- in_A  in  DATA_WIDTH  operand A.
- in_B  in  DATA_WIDTH  operand B.
- in_ALUop  in  3  operation code.
- in_tag  in  TAG_W  packet tag.
- alu_A  out  DATA_WIDTH  operand register A, drives ALU A.
- alu_B  out  DATA_WIDTH  operand register B, drives ALU B.
- alu_ALUop  out  3  operand register op, drives ALU ALUop.
- alu_Result  in  DATA_WIDTH  ALU Result.
- alu_Zero  in  1  ALU Zero.
- alu_Overflow  in  1  ALU Overflow.
- alu_CarryOut  in  1  ALU CarryOut.
- out_valid  out  1  result packet valid.
- out_ready  in  1  writeback accepts the packet.
- out_result  out  DATA_WIDTH  result.
- out_zero  out  1  result==0.
- out_overflow  out  1  signed overflow; ADD/SUB only.
- out_carry  out  1  carry/borrow; ADD/SUB only.
- out_illegal  out  1  ALUop was not one of the five legal codes.
- out_tag  out  TAG_W  tag of the packet.
- stat_clear  in  1  synchronous clear of overflow statistics.
- ovf_sticky  out  1  set by any enqueued overflow.
- ovf_count  out  CNT_W  saturating count of enqueued overflows.

Behaviour:
Reset (resetn=0, asynchronous):
- op_valid=0; queue count=0; out_valid=0.
- alu_A/alu_B/alu_ALUop/out_result/out_tag all 0; all out_* flags 0.
- ovf_sticky=0; ovf_count=0.
- in_ready=1 from the first cycle after reset release.
- Reset mid-operation discards all in-flight packets with no output.

Fire conditions:
- in_fire = in_valid & in_ready.
- out_fire = out_valid & out_ready.
- out_valid = (count!=0).

Operand register:
- adv = op_valid & (count<2 | out_fire).
- in_ready = ~op_valid | adv. This is combinational from out_ready, giving full throughput.
- On in_fire, load A, B, ALUop and tag; op_valid=1.
- On adv without in_fire, op_valid=0. The alu_* ports hold their last value.

Capture at an adv edge (queue write, same edge as operand advance):
- result = alu_Result; zero = alu_Zero.
- overflow/carry = alu_Overflow/alu_CarryOut only when op is ADD or SUB; otherwise 0. The ALU drives X there, so X must never reach the outputs.
- SLT: result is alu_Result (0 or 1); overflow=carry=0.
- Illegal op (011/100/101): result=0, zero=1, overflow=carry=0, illegal=1.

Latency and ordering:
- A packet accepted at edge t is captured at edge t+1 when the queue has room. out_valid is high in the cycle after t+1.
- Results leave strictly in order.

Output queue:
- 2-entry FIFO; the head drives out_*.
- Simultaneous write and out_fire when count==2 is legal: count stays 2 and order is preserved.
- Simultaneous write and out_fire when count==1: the new entry becomes the head next cycle.
- Output data must be stable while out_valid=1 and out_ready=0.

Statistics (counted at enqueue of a packet with sanitised overflow=1):
- ovf_sticky is set to 1.
- ovf_count increments, saturating at 2^CNT_W-1.
- stat_clear has priority: it clears both. Clear and increment in the same cycle yields ovf_sticky=1, ovf_count=1.

Test Plan:
1. Reset, then ADD A=0x7FFFFFFF, B=1, tag=3 -> two edges later out_result=0x80000000, out_overflow=1, out_carry=0, out_tag=3; ovf_sticky=1, ovf_count=1.
2. Back-to-back SUB 5-5, SLT -1<1, AND 0xF0F0&0x0FF0 with out_ready=1 -> one result per cycle, in order: (0, zero=1), (1, ovf=0, carry=0), (0x00F0).
3. out_ready=0, issue 4 packets -> 2 queued + 1 in operand reg, in_ready=0 on the 4th until out_ready=1. Then drain in order with no loss or duplication, and data is stable while stalled.
4. ALUop=3'b101, A=7, B=9 -> out_result=0, out_zero=1, out_illegal=1, overflow=carry=0 (no X).
5. CNT_W=2: five overflowing ADDs -> ovf_count saturates at 3. stat_clear asserted coincident with a sixth overflow -> ovf_count=1, ovf_sticky=1.
6. Assert resetn=0 with 3 packets in flight -> outputs zero immediately. After release, out_valid stays 0 until new input.
